mcpu_regfile: RTL and testbench

- 32 x 32-bit general register file for the multicycle CPU.
- Sits directly downstream of the 5-bit register-destination 4:1 select. That select chooses rd, rt, constant 31 (link) or a spare source. Its output drives wt_addr here.
- Provides two combinational read ports for the A/B operand latches, plus one debug read port for the board display.
- Also keeps a committed-write counter for debug.

---
 rtl/mcpu_pkg.sv | 33 +++
 rtl/mcpu_regfile.sv | 97 +++++++++
 tb/tb_mcpu_regfile.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_pkg.sv
// Shared definitions for the multicycle CPU datapath: widths, named
// register numbers and the register-destination select encodings.
package mcpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Architecturally named registers
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Register-destination select (drives the regfile write address)
  typedef enum logic [1:0] {
    DST_RT    = 2'b00,
    DST_RD    = 2'b01,
    DST_RA    = 2'b10,
    DST_SPARE = 2'b11
  } dst_sel_e;

  // Destination register chosen by the 4:1 select
  function automatic logic [4:0] dst_addr(input dst_sel_e sel,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd,
                                          input logic [4:0] spare);
    case (sel)
      DST_RT:  dst_addr = rt;
      DST_RD:  dst_addr = rd;
      DST_RA:  dst_addr = REG_RA;
      default: dst_addr = spare;
    endcase
  endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// 32 x 32 general register file: two combinational operand read ports with
// optional same-cycle write forwarding, one unforwarded debug read port, and
// a committed-write counter. Register 0 always reads as zero.
module mcpu_regfile #(
  parameter int DATA_W = mcpu_pkg::DATA_W,
  parameter int ADDR_W = mcpu_pkg::ADDR_W,
  parameter int BYPASS = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wt_addr,
  input  logic [DATA_W-1:0] wt_data,
  input  logic [ADDR_W-1:0] r_addr_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_cnt
);

  import mcpu_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [0:DEPTH-1];
  logic              commit;

  // A write only commits (stores and counts) when it targets a real register
  assign commit = we && (wt_addr != ZERO_ADDR);

  // Forwarding hit for one read port; never active while reset is held
  function automatic logic bypass_hit(input logic              rst_i,
                                      input logic              commit_i,
                                      input logic [ADDR_W-1:0] waddr,
                                      input logic [ADDR_W-1:0] raddr);
    bypass_hit = (BYPASS != 0) && !rst_i && commit_i && (waddr == raddr);
  endfunction

  // Register storage: async clear, store committed writes on the rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[wt_addr] <= wt_data;
    end
  end

  // Committed-write counter, wraps freely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (commit) begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // Port A: zero register, then forwarding, then stored value
  always_comb begin
    rdata_a = '0;
    if (rst || r_addr_a == ZERO_ADDR) begin
      rdata_a = '0;
    end else if (bypass_hit(rst, commit, wt_addr, r_addr_a)) begin
      rdata_a = wt_data;
    end else begin
      rdata_a = regs[r_addr_a];
    end
  end

  // Port B: same rules as port A, evaluated independently
  always_comb begin
    rdata_b = '0;
    if (rst || r_addr_b == ZERO_ADDR) begin
      rdata_b = '0;
    end else if (bypass_hit(rst, commit, wt_addr, r_addr_b)) begin
      rdata_b = wt_data;
    end else begin
      rdata_b = regs[r_addr_b];
    end
  end

  // Debug port always shows the stored (pre-write) contents
  always_comb begin
    dbg_data = '0;
    if (rst || dbg_addr == ZERO_ADDR) begin
      dbg_data = '0;
    end else begin
      dbg_data = regs[dbg_addr];
    end
  end

endmodule

// File: tb/tb_mcpu_regfile.sv
// Bench for mcpu_regfile: three instances share one stimulus stream
// (no bypass / bypass / 4-bit counter) and are checked against hand-computed
// vectors plus reset, counter-wrap and readback sequences.
module tb_mcpu_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wt_addr;
  logic [31:0] wt_data;
  logic [4:0]  r_addr_a;
  logic [4:0]  r_addr_b;
  logic [4:0]  dbg_addr;

  logic [31:0] n_rdata_a, n_rdata_b, n_dbg_data;
  logic [15:0] n_wr_cnt;
  logic [31:0] b_rdata_a, b_rdata_b, b_dbg_data;
  logic [15:0] b_wr_cnt;
  logic [31:0] w_rdata_a, w_rdata_b, w_dbg_data;
  logic [3:0]  w_wr_cnt;

  int n_checks;
  int n_errors;

  logic [31:0] exp_q[$];

  mcpu_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(16)) dut_n (
    .clk(clk), .rst(rst), .we(we), .wt_addr(wt_addr), .wt_data(wt_data),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
    .rdata_a(n_rdata_a), .rdata_b(n_rdata_b),
    .dbg_addr(dbg_addr), .dbg_data(n_dbg_data), .wr_cnt(n_wr_cnt)
  );

  mcpu_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .we(we), .wt_addr(wt_addr), .wt_data(wt_data),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
    .rdata_a(b_rdata_a), .rdata_b(b_rdata_b),
    .dbg_addr(dbg_addr), .dbg_data(b_dbg_data), .wr_cnt(b_wr_cnt)
  );

  mcpu_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .we(we), .wt_addr(wt_addr), .wt_data(wt_data),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
    .rdata_a(w_rdata_a), .rdata_b(w_rdata_b),
    .dbg_addr(dbg_addr), .dbg_data(w_dbg_data), .wr_cnt(w_wr_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  dbg;
    logic [31:0] ea;    // no-bypass port A before the edge
    logic [31:0] eb;    // no-bypass port B before the edge
    logic [31:0] ed;    // debug (both instances) before the edge
    logic [31:0] eba;   // bypass port A before the edge
    logic [31:0] ebb;   // bypass port B before the edge
    int          ecnt;  // committed writes after the edge
  } vec_t;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] LK = 32'h0040_0008;

  vec_t vecs [13];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
    we = w; wt_addr = wa; wt_data = wd;
    r_addr_a = ra; r_addr_b = rb; dbg_addr = da;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input int exp);
    check({name, "_cnt_n"}, 32'(n_wr_cnt), 32'(exp % 65536));
    check({name, "_cnt_w"}, 32'(w_wr_cnt), 32'(exp % 16));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_a_n", n_rdata_a, 32'h0);
    check("rst_dbg_n", n_dbg_data, 32'h0);
    check_cnt("rst", 0);
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] e;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    we = 1'b0; wt_addr = '0; wt_data = '0;
    r_addr_a = 5'd5; r_addr_b = 5'd31; dbg_addr = 5'd7;

    vecs[0]  = '{1'b1, 5'd5,  DB,           5'd5,  5'd0,  5'd5,  0,      0,      0,      DB,     0,      1};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  DB,     DB,     DB,     DB,     DB,     1};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  0,      0,      0,      0,      0,      1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  5'd0,  0,      DB,     0,      0,      DB,     1};
    vecs[4]  = '{1'b1, 5'd31, LK,           5'd5,  5'd31, 5'd31, DB,     0,      0,      DB,     LK,     2};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31, LK,     LK,     LK,     LK,     LK,     2};
    vecs[6]  = '{1'b1, 5'd7,  32'h1,        5'd7,  5'd7,  5'd7,  0,      0,      0,      1,      1,      3};
    vecs[7]  = '{1'b1, 5'd7,  32'h2,        5'd7,  5'd7,  5'd7,  1,      1,      1,      2,      2,      4};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  5'd7,  2,      2,      2,      2,      2,      4};
    vecs[9]  = '{1'b1, 5'd9,  32'h1234,     5'd9,  5'd9,  5'd9,  0,      0,      0,      32'h1234, 32'h1234, 5};
    vecs[10] = '{1'b1, 5'd10, 32'hABCD,     5'd9,  5'd10, 5'd9,  32'h1234, 0,    32'h1234, 32'h1234, 32'hABCD, 6};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd10, 5'd9,  5'd5,  32'hABCD, 32'h1234, DB, 32'hABCD, 32'h1234, 6};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd31, 5'd10, 2,      LK,     32'hABCD, 2,    LK,     6};

    // reset state
    #1;
    check("init_rst_b_a", b_rdata_a, 32'h0);
    do_reset();
    check_cnt("post_rst", 0);

    // table-driven vectors: check combinational reads, take the edge, check counter
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, vecs[i].dbg);
      check($sformatf("v%0d_a_n", i), n_rdata_a, vecs[i].ea);
      check($sformatf("v%0d_b_n", i), n_rdata_b, vecs[i].eb);
      check($sformatf("v%0d_dbg_n", i), n_dbg_data, vecs[i].ed);
      check($sformatf("v%0d_a_b", i), b_rdata_a, vecs[i].eba);
      check($sformatf("v%0d_b_b", i), b_rdata_b, vecs[i].ebb);
      check($sformatf("v%0d_dbg_b", i), b_dbg_data, vecs[i].ed);
      step();
      check_cnt($sformatf("v%0d", i), vecs[i].ecnt);
    end

    // reset mid-run clears immediately, no clock edge needed
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 5'd5);
    check("pre_rst_a", n_rdata_a, DB);
    rst = 1'b1;
    #1;
    check("midrst_a_n", n_rdata_a, 32'h0);
    check("midrst_b_n", n_rdata_b, 32'h0);
    check("midrst_dbg_b", b_dbg_data, 32'h0);
    check_cnt("midrst", 0);
    // write presented while reset held: not forwarded, dropped at the edge
    drive(1'b1, 5'd5, 32'h55, 5'd5, 5'd5, 5'd5);
    check("rstwr_a_b", b_rdata_a, 32'h0);
    step();
    check("rstwr_dbg_n", n_dbg_data, 32'h0);
    check_cnt("rstwr", 0);
    // release reset with the write still presented: accepted on the next edge
    rst = 1'b0;
    #1;
    check("rel_a_n", n_rdata_a, 32'h0);
    check("rel_a_b", b_rdata_a, 32'h55);
    step();
    check("rel_post_a_n", n_rdata_a, 32'h55);
    check_cnt("rel_post", 1);

    // counter wrap plus readback scoreboard
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      d = $urandom_range(32'h7FFF_FFFF, 1);
      drive(1'b1, 5'(i), d, 5'd0, 5'd0, 5'd0);
      exp_q.push_back(d);
      step();
      if (i == 16) check_cnt("wrap16", 16);
    end
    check_cnt("wrap17", 17);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i <= 17; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(18 - i), 5'(i));
      e = exp_q.pop_front();
      check($sformatf("rb%0d_dbg", i), n_dbg_data, e);
      check($sformatf("rb%0d_a_b", i), b_rdata_a, e);
    end
    // untouched registers stay zero
    drive(1'b0, 5'd0, 32'h0, 5'd20, 5'd31, 5'd25);
    check("untouched_a", n_rdata_a, 32'h0);
    check("untouched_b", n_rdata_b, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
